// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg
// Definitions shared by the I2C master blocks:
//   - master_state_e : 4-bit SDA-FSM state encoding seen on state_master
//   - DEF_*          : default bit-timing parameters
//   - is_bit_state   : true for states that clock out / in a bit on SCL
package i2c_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE            = 4'd0,
    ST_READY           = 4'd1,
    ST_SEND_ADDRESS    = 4'd2,
    ST_WRITE_DATA      = 4'd3,
    ST_OUTPUT_DATA     = 4'd4,
    ST_CHECK_ACK       = 4'd5,
    ST_READ_DATA       = 4'd6,
    ST_STORE_DATA      = 4'd7,
    ST_CHECK_FOR_VALID = 4'd8,
    ST_SEND_ACK        = 4'd9,
    ST_SEND_NACK       = 4'd10,
    ST_STOP            = 4'd11
  } master_state_e;

  localparam int DEF_T_LOW           = 6;
  localparam int DEF_T_HIGH          = 4;
  localparam int DEF_SETUP_SDA_START = 2;
  localparam int DEF_T_HOLD_START    = 4;
  localparam int DEF_ADDR_LEN        = 7;
  localparam int DEF_DATA_LEN        = 8;
  localparam int DEF_CNT_W           = 7;

  function automatic logic is_bit_state(input master_state_e st);
    case (st)
      ST_SEND_ADDRESS, ST_READ_DATA, ST_WRITE_DATA, ST_OUTPUT_DATA,
      ST_CHECK_ACK, ST_STORE_DATA, ST_CHECK_FOR_VALID, ST_SEND_ACK,
      ST_SEND_NACK: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous input line.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (two clk edges of latency)
// RST_VAL sets the value both flops take in reset, so an idle-high bus line
// does not look like a falling edge right after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/scl_timing_gen.sv
// scl_timing_gen
// Bit-timing and SCL generator for the I2C master. Produces the SCL drive,
// the intra-bit phase counter, the bit index and the one-cycle phase strobes
// consumed by the SDA FSM, and freezes the bit timing while a slave stretches
// the clock.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   state_master   : SDA FSM state code (master_state_e)
//   rst_count      : synchronous clear of count_ctrl (SCL holds its value)
//   rst_count_2    : synchronous clear of count
//   scl_in         : SCL line as seen on the bus (asynchronous)
//   scl            : SCL drive, 1 = release, 0 = pull low
//   count_ctrl     : intra-bit phase counter
//   count          : bit index within the current frame (saturates at 15)
//   wait_for_sync  : pulse at the end of the START hold
//   add_sent       : pulse at the end of the R/W bit
//   data_sent      : pulse at the end of the last written data bit
//   data_received  : pulse at the end of the last read data bit
//   stretching     : high while the slave holds SCL low
module scl_timing_gen
  import i2c_master_pkg::*;
#(
  parameter int T_LOW           = DEF_T_LOW,
  parameter int T_HIGH          = DEF_T_HIGH,
  parameter int SETUP_SDA_START = DEF_SETUP_SDA_START,
  parameter int T_HOLD_START    = DEF_T_HOLD_START,
  parameter int ADDR_LEN        = DEF_ADDR_LEN,
  parameter int DATA_LEN        = DEF_DATA_LEN,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       state_master,
  input  logic             rst_count,
  input  logic             rst_count_2,
  input  logic             scl_in,
  output logic             scl,
  output logic [CNT_W-1:0] count_ctrl,
  output logic [3:0]       count,
  output logic             wait_for_sync,
  add_sent,
  output logic             data_sent,
  output logic             data_received,
  output logic             stretching
);

  localparam int PERIOD = T_LOW + T_HIGH;

  localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(T_LOW);
  localparam logic [CNT_W-1:0] STRETCH_C = CNT_W'(T_LOW + 1);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] SYNC_C    = CNT_W'(SETUP_SDA_START + T_HOLD_START - 1);
  localparam logic [CNT_W-1:0] MAX_C     = '1;
  localparam logic [3:0]       ADDR_LAST_C = 4'(ADDR_LEN);
  localparam logic [3:0]       DATA_LAST_C = 4'(DATA_LEN - 1);

  master_state_e    st;
  logic             bit_state;
  logic             scl_s;
  logic             freeze;
  logic             at_last;
  logic             strobe_ok;
  logic [CNT_W-1:0] ctrl_inc;

  logic             scl_q, scl_d;
  logic [CNT_W-1:0] count_ctrl_q, count_ctrl_d;
  logic [3:0]       count_q, count_d;

  // SCL idles high, so the synchronizer resets to 1 to avoid a phantom
  // stretch right after reset.
  sync_2ff #(.RST_VAL(1'b1)) u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (scl_in),
    .q     (scl_s)
  );

  // Codes 12..15 are not states; they behave like Idle.
  always_comb begin
    st = ST_IDLE;
    if (state_master <= ST_STOP) st = master_state_e'(state_master);
  end

  assign bit_state = is_bit_state(st);
  assign at_last   = (count_ctrl_q == LAST_C);
  assign ctrl_inc  = (count_ctrl_q == MAX_C) ? MAX_C : count_ctrl_q + 1'b1;

  // We released SCL one cycle ago but the slave still holds it low: stay on
  // this phase until the synchronized line comes back high.
  assign freeze = bit_state && scl_q && (count_ctrl_q == STRETCH_C) && !scl_s;

  always_comb begin
    count_ctrl_d = count_ctrl_q;
    count_d      = count_q;
    scl_d        = scl_q;

    case (st)
      ST_IDLE: begin
        count_ctrl_d = '0;
        count_d      = '0;
        scl_d        = 1'b1;
      end
      ST_READY: begin
        // SCL is released through the START setup and hold, then pulled
        // low on the cycle after wait_for_sync.
        count_ctrl_d = ctrl_inc;
        scl_d        = (count_ctrl_q < SYNC_C);
      end
      ST_STOP: begin
        // Finish the low phase, then release SCL for good; the counter
        // parks at its maximum so it never re-enters the low phase.
        count_ctrl_d = ctrl_inc;
        scl_d        = (ctrl_inc >= LOW_C);
      end
      default: begin
        // Only bit states reach here after the decode above.
        if (!freeze) begin
          if (at_last) begin
            count_ctrl_d = '0;
            if (count_q != 4'hF) count_d = count_q + 4'd1;
          end else begin
            count_ctrl_d = count_ctrl_q + 1'b1;
          end
          scl_d = (count_ctrl_d >= LOW_C);
        end
      end
    endcase

    // The SDA FSM re-aligns the phase with rst_count; SCL keeps its level
    // so the realignment never produces a glitch on the bus.
    if (rst_count && st != ST_IDLE) begin
      count_ctrl_d = '0;
      count_d      = count_q;
      scl_d        = scl_q;
    end

    if (rst_count_2) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q        <= 1'b1;
      count_ctrl_q <= '0;
      count_q      <= '0;
    end else begin
      scl_q        <= scl_d;
      count_ctrl_q <= count_ctrl_d;
      count_q      <= count_d;
    end
  end

  // Strobes are decoded from the registered counters so they line up with
  // the count_ctrl value they describe.
  assign strobe_ok     = at_last && !freeze;
  assign wait_for_sync = (st == ST_READY) && (count_ctrl_q == SYNC_C);
  assign add_sent      = (st == ST_SEND_ADDRESS) && (count_q == ADDR_LAST_C) && strobe_ok;
  assign data_sent     = (st == ST_OUTPUT_DATA) && (count_q == DATA_LAST_C) && strobe_ok;
  assign data_received = (st == ST_STORE_DATA) && (count_q == DATA_LAST_C) && strobe_ok;
  assign stretching    = freeze;

  assign scl        = scl_q;
  assign count_ctrl = count_ctrl_q;
  assign count      = count_q;

endmodule
